// File: rtl/centroid_update_seq.sv
// k-means centroid-update sequencer: per slot read accumulator/count, divide, narrow, write centroid.
// Optional macro CENT_QUOT_SAT_EN: saturate lane quotients instead of wrapping to cordinate_width.
module centroid_update_seq #(
  parameter int centroid_num     = 8,
  parameter int addrWidth        = 8,
  parameter int accum_cord_width = 22,
  parameter int accum_width      = 7 * accum_cord_width,
  parameter int cordinate_width  = 13,
  parameter int dataWidth        = 7 * cordinate_width,
  parameter int count_width      = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  output logic                    acc_rd_en,
  output logic [addrWidth-1:0]    acc_rd_addr,
  input  logic [accum_width-1:0]  acc_rd_data,
  input  logic [count_width-1:0]  cnt_rd_data,
  output logic [accum_width-1:0]  div_accum,
  output logic [count_width-1:0]  div_counter,
  input  logic [accum_width-1:0]  div_quot,
  input  logic                    div_by_zero,
  output logic                    cent_wr_en,
  output logic [addrWidth-1:0]    cent_wr_addr,
  output logic [dataWidth-1:0]    cent_wr_data,
  output logic                    busy,
  output logic                    done,
  output logic [centroid_num-1:0] empty_mask
);

  localparam int LANES = 7;
  localparam logic [addrWidth-1:0] LAST_SLOT = addrWidth'(centroid_num - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_CAP,
    S_DIV,
    S_WR,
    S_DONE
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [addrWidth-1:0]   slot;
  logic                   skip;
  logic                   done_q;
  logic [dataWidth-1:0]   quot_narrow;

`ifdef CENT_QUOT_SAT_EN
  localparam logic signed [accum_cord_width-1:0] QMAX =
    accum_cord_width'((2 ** (cordinate_width - 1)) - 1);
  localparam logic signed [accum_cord_width-1:0] QMIN =
    accum_cord_width'(-(2 ** (cordinate_width - 1)));

  function automatic logic [cordinate_width-1:0] narrow(
    input logic signed [accum_cord_width-1:0] q
  );
    if (q > QMAX)      return QMAX[cordinate_width-1:0];
    else if (q < QMIN) return QMIN[cordinate_width-1:0];
    else               return q[cordinate_width-1:0];
  endfunction
`else
  // Wrap-around: keep only the low coordinate bits of each quotient.
  function automatic logic [cordinate_width-1:0] narrow(
    input logic signed [accum_cord_width-1:0] q
  );
    return q[cordinate_width-1:0];
  endfunction
`endif

  always_comb begin
    // NOTE: every signal written in a combinational block gets a default first, otherwise a latch is inferred.
    quot_narrow = '0;
    for (int i = 0; i < LANES; i++) begin
      quot_narrow[i*cordinate_width +: cordinate_width] =
        narrow(div_quot[i*accum_cord_width +: accum_cord_width]);
    end
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RD;
      S_RD:    state_nxt = S_CAP;
      S_CAP:   state_nxt = S_DIV;
      S_DIV:   state_nxt = S_WR;
      S_WR:    state_nxt = (slot == LAST_SLOT) ? S_DONE : S_RD;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath registers; the divider sits combinationally between div_* and div_quot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot         <= '0;
      skip         <= 1'b0;
      done_q       <= 1'b0;
      div_accum    <= '0;
      div_counter  <= '0;
      cent_wr_data <= '0;
      empty_mask   <= '0;
    end else begin
      done_q <= (state == S_DONE);
      case (state)
        S_IDLE: begin
          if (start) begin
            slot       <= '0;
            empty_mask <= '0;
          end
        end
        S_CAP: begin
          div_accum   <= acc_rd_data;
          div_counter <= cnt_rd_data;
        end
        S_DIV: begin
          cent_wr_data <= quot_narrow;
          skip         <= div_by_zero;
        end
        S_WR: begin
          for (int i = 0; i < centroid_num; i++) begin
            if (skip && (slot == addrWidth'(i))) empty_mask[i] <= 1'b1;
          end
          if (slot != LAST_SLOT) slot <= slot + addrWidth'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    acc_rd_en    = 1'b0;
    acc_rd_addr  = '0;
    cent_wr_en   = 1'b0;
    cent_wr_addr = '0;
    case (state)
      S_RD: begin
        acc_rd_en   = 1'b1;
        acc_rd_addr = slot;
      end
      S_WR: begin
        // Empty slots keep their old centroid.
        if (!skip) begin
          cent_wr_en   = 1'b1;
          cent_wr_addr = slot;
        end
      end
      default: ;
    endcase
  end

  assign busy = (state != S_IDLE);
  assign done = done_q;

endmodule

// File: tb/tb_centroid_update_seq.sv
// Self-checking bench for centroid_update_seq: RAM and divider models, write scoreboard, directed passes.
// Expected narrowing follows CENT_QUOT_SAT_EN when the macro is defined for the build.
module tb_centroid_update_seq;

  localparam int NC = 8;
  localparam int AW = 8;
  localparam int CW = 22;
  localparam int ACW = 7 * CW;
  localparam int DW = 13;
  localparam int DDW = 7 * DW;
  localparam int KW = 10;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic            acc_rd_en;
  logic [AW-1:0]   acc_rd_addr;
  logic [ACW-1:0]  acc_rd_data;
  logic [KW-1:0]   cnt_rd_data;
  logic [ACW-1:0]  div_accum;
  logic [KW-1:0]   div_counter;
  logic [ACW-1:0]  div_quot;
  logic            div_by_zero;
  logic            cent_wr_en;
  logic [AW-1:0]   cent_wr_addr;
  logic [DDW-1:0]  cent_wr_data;
  logic            busy;
  logic            done;
  logic [NC-1:0]   empty_mask;

  centroid_update_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .acc_rd_en(acc_rd_en), .acc_rd_addr(acc_rd_addr),
    .acc_rd_data(acc_rd_data), .cnt_rd_data(cnt_rd_data),
    .div_accum(div_accum), .div_counter(div_counter),
    .div_quot(div_quot), .div_by_zero(div_by_zero),
    .cent_wr_en(cent_wr_en), .cent_wr_addr(cent_wr_addr), .cent_wr_data(cent_wr_data),
    .busy(busy), .done(done), .empty_mask(empty_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory models
  logic [ACW-1:0] acc_mem [NC];
  logic [KW-1:0]  cnt_mem [NC];
  logic [DDW-1:0] cent_mem [NC];
  localparam logic [DDW-1:0] SENTINEL = {7{13'h0AAA}};

  always @(posedge clk) begin
    if (acc_rd_en) begin
      acc_rd_data <= acc_mem[acc_rd_addr[2:0]];
      cnt_rd_data <= cnt_mem[acc_rd_addr[2:0]];
    end
    if (cent_wr_en) cent_mem[cent_wr_addr[2:0]] <= cent_wr_data;
  end

  // Divider model: signed per-lane quotient truncated toward zero
  function automatic logic [ACW:0] div_model(input logic [ACW-1:0] acc, input logic [KW-1:0] cnt);
    logic [ACW-1:0] q;
    logic signed [CW-1:0] l;
    int a, c, r;
    q = '0;
    c = int'(cnt);
    if (c == 0) return {1'b1, q};
    for (int i = 0; i < 7; i++) begin
      l = acc[i*CW +: CW];
      a = l;
      r = a / c;
      q[i*CW +: CW] = r[CW-1:0];
    end
    return {1'b0, q};
  endfunction

  always_comb {div_by_zero, div_quot} = div_model(div_accum, div_counter);

  function automatic logic [DW-1:0] exp_narrow(input int q);
`ifdef CENT_QUOT_SAT_EN
    int s;
    s = q;
    if (s > 4095) s = 4095;
    if (s < -4096) s = -4096;
    return s[DW-1:0];
`else
    return q[DW-1:0];
`endif
  endfunction

  function automatic logic [DDW-1:0] exp_word(input logic [ACW-1:0] acc, input logic [KW-1:0] cnt);
    logic [DDW-1:0] w;
    logic signed [CW-1:0] l;
    int a;
    w = '0;
    for (int i = 0; i < 7; i++) begin
      l = acc[i*CW +: CW];
      a = l;
      w[i*DW +: DW] = exp_narrow(a / int'(cnt));
    end
    return w;
  endfunction

  function automatic logic [ACW-1:0] set_lane(input logic [ACW-1:0] acc, input int i, input int v);
    logic [ACW-1:0] r;
    r = acc;
    r[i*CW +: CW] = v[CW-1:0];
    return r;
  endfunction

  // Scoreboard of expected centroid writes
  typedef struct {
    logic [AW-1:0]  addr;
    logic [DDW-1:0] data;
    int             cyc;
  } exp_t;
  exp_t sb[$];

  task automatic push_pass();
    exp_t e;
    for (int k = 0; k < NC; k++) begin
      if (cnt_mem[k] != '0) begin
        e.addr = AW'(k);
        e.data = exp_word(acc_mem[k], cnt_mem[k]);
        e.cyc  = 4 + 4 * k;
        sb.push_back(e);
      end
    end
  endtask

  function automatic logic [NC-1:0] exp_mask();
    logic [NC-1:0] m;
    for (int k = 0; k < NC; k++) m[k] = (cnt_mem[k] == '0);
    return m;
  endfunction

  int edge_cnt = 0;
  int start_edge = 0;

  always @(posedge clk) begin
    edge_cnt++;
    if (start && !busy && rst_n) start_edge = edge_cnt;
  end

  always @(negedge clk) begin
    exp_t e;
    int cyc;
    cyc = edge_cnt - start_edge + 1;
    if (cent_wr_en) begin
      chk("write_expected", (sb.size() != 0), 1'b1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("wr_addr", cent_wr_addr, e.addr);
        chk("wr_data", cent_wr_data, e.data);
        chk("wr_cycle", cyc, e.cyc);
      end
    end
    if (done) chk("done_latency", cyc, 34);
  end

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(tag, (n < 200), 1'b1);
  endtask

  task automatic run_pass(input string tag);
    push_pass();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(tag);
    chk({tag, "_mask"}, empty_mask, exp_mask());
    chk({tag, "_sb_empty"}, sb.size(), 0);
  endtask

  task automatic clear_mems();
    for (int k = 0; k < NC; k++) begin
      acc_mem[k]  = {7{22'h15A5A}};
      cnt_mem[k]  = '0;
      cent_mem[k] = SENTINEL;
    end
  endtask

  initial begin
    logic [ACW-1:0] a;
    int n;
    rst_n = 1'b0;
    start = 1'b0;
    clear_mems();
    #1;
    chk("reset_outputs",
        {acc_rd_en, acc_rd_addr, div_accum, div_counter, cent_wr_en, cent_wr_addr,
         cent_wr_data, busy, done, empty_mask}, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Single slot: only slot 0 has points
    clear_mems();
    acc_mem[0] = set_lane('0, 0, -100);
    cnt_mem[0] = 10'd3;
    run_pass("single");
    chk("single_cord1", cent_mem[0], {78'd0, 13'h1FDF});
    chk("single_slot1_kept", cent_mem[1], SENTINEL);
    chk("single_mask_const", empty_mask, 8'hFE);
    repeat (3) @(negedge clk);
    chk("single_mask_hold", empty_mask, 8'hFE);
    chk("idle_busy", busy, 1'b0);

    // All slots, distinct lane values including negatives
    clear_mems();
    for (int k = 0; k < NC; k++) begin
      a = '0;
      for (int i = 0; i < 7; i++) a = set_lane(a, i, (i == 6 ? -1 : 1) * 4 * (100 + 10 * i + k));
      acc_mem[k] = a;
      cnt_mem[k] = 10'd4;
    end
    acc_mem[3] = {7{22'd400}};
    run_pass("all");
    chk("all_slot3_100", cent_mem[3], {7{13'd100}});
    chk("all_mask_zero", empty_mask, 8'h00);

    // Overflow and max-count boundaries
    clear_mems();
    acc_mem[0] = set_lane('0, 0, 1 << 20);
    cnt_mem[0] = 10'd1;
    acc_mem[1] = set_lane('0, 0, -(1 << 20));
    cnt_mem[1] = 10'd1;
    acc_mem[2] = set_lane(set_lane('0, 1, 5000), 0, -2097152);
    cnt_mem[2] = 10'd1023;
    run_pass("ovf");
`ifdef CENT_QUOT_SAT_EN
    chk("ovf_pos", cent_mem[0][12:0], 13'h0FFF);
    chk("ovf_neg", cent_mem[1][12:0], 13'h1000);
`else
    chk("ovf_pos", cent_mem[0][12:0], 13'h0000);
    chk("ovf_neg", cent_mem[1][12:0], 13'h0000);
`endif
    chk("maxcnt_cord1", cent_mem[2][12:0], 13'h17FE);
    chk("maxcnt_cord2", cent_mem[2][25:13], 13'd4);

    // start held high: exactly one pass, then a fresh pass from IDLE
    clear_mems();
    acc_mem[0] = {7{22'd50}};
    cnt_mem[0] = 10'd5;
    acc_mem[5] = {7{-22'sd70}};
    cnt_mem[5] = 10'd7;
    push_pass();
    push_pass();
    @(negedge clk);
    start = 1'b1;
    wait_done("held_first_done");
    chk("held_busy_gap", busy, 1'b0);
    @(negedge clk);
    chk("held_restart", busy, 1'b1);
    start = 1'b0;
    wait_done("held_second_done");
    repeat (4) @(negedge clk);
    chk("held_no_third", busy, 1'b0);
    chk("held_sb_empty", sb.size(), 0);
    chk("held_mask", empty_mask, 8'hDE);

    // Reset asserted during the write of slot 3
    clear_mems();
    for (int k = 0; k < NC; k++) begin
      acc_mem[k] = set_lane(set_lane('0, 0, 30 * (k + 1)), 6, -9 * (k + 2));
      cnt_mem[k] = 10'd3;
    end
    push_pass();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!(cent_wr_en && cent_wr_addr == 8'd3) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("rst_reach_slot3", (n < 100), 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_async_outputs",
        {acc_rd_en, acc_rd_addr, div_accum, div_counter, cent_wr_en, cent_wr_addr,
         cent_wr_data, busy, done, empty_mask}, '0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("rst_stays_idle", busy, 1'b0);
    for (int k = 0; k < 3; k++) chk("rst_prior_written", cent_mem[k], exp_word(acc_mem[k], cnt_mem[k]));
    chk("rst_slot3_kept", cent_mem[3], SENTINEL);
    chk("rst_slot4_kept", cent_mem[4], SENTINEL);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
